// File: rtl/sram_arbiter_if.sv
// Requester/SRAM-facing signal bundle for sram_arbiter.
// slave = arbiter side; master = requesters plus the SRAM macro model.
interface sram_arbiter_if;
  logic        im_req;
  logic [13:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;

  logic        dm_req;
  logic [3:0]  dm_web;
  logic [13:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  logic        sram_cs;
  logic        sram_oe;
  logic [3:0]  sram_web;
  logic [13:0] sram_a;
  logic [31:0] sram_di;
  logic [31:0] sram_do;

  modport slave (
    input  im_req, im_addr, dm_req, dm_web, dm_addr, dm_wdata, sram_do,
    output im_gnt, im_rvalid, im_rdata, dm_gnt, dm_rvalid, dm_rdata,
           sram_cs, sram_oe, sram_web, sram_a, sram_di
  );

  modport master (
    output im_req, im_addr, dm_req, dm_web, dm_addr, dm_wdata, sram_do,
    input  im_gnt, im_rvalid, im_rdata, dm_gnt, dm_rvalid, dm_rdata,
           sram_cs, sram_oe, sram_web, sram_a, sram_di
  );
endinterface

// File: rtl/sram_arbiter.sv
// IF/MEM arbiter for one shared single-port SRAM; routes late read data to its owner.
// SRAM_ARB_RR_EN: round-robin on conflict instead of DM priority with IM starvation override.
module sram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {RD_NONE = 2'd0, RD_IM = 2'd1, RD_DM = 2'd2} rd_owner_e;

  rd_owner_e   rd_owner, rd_owner_nxt;
  logic        im_win, im_gnt, dm_gnt, dm_rd;
  logic [31:0] im_hold, dm_hold;

`ifdef SRAM_ARB_RR_EN
  // rr_ptr = 1 means IM wins the next conflict; only conflicts move it
  logic rr_ptr;
  assign im_win = rr_ptr;

  always_ff @(posedge clk or negedge rst)
    if (!rst)                          rr_ptr <= 1'b0;
    else if (bus.im_req && bus.dm_req) rr_ptr <= ~rr_ptr;
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;
  assign im_win = (starve_cnt == LIMIT);

  always_ff @(posedge clk or negedge rst)
    if (!rst)                             starve_cnt <= '0;
    else if (!bus.im_req || im_gnt)       starve_cnt <= '0;
    else if (starve_cnt != LIMIT)         starve_cnt <= starve_cnt + 4'd1;
`endif

  // rst gating keeps the handshake quiet while reset is held
  assign im_gnt = rst & bus.im_req & (~bus.dm_req | im_win);
  assign dm_gnt = rst & bus.dm_req & ~im_gnt;
  assign dm_rd  = dm_gnt & (bus.dm_web == 4'hF);

  assign bus.im_gnt = im_gnt;
  assign bus.dm_gnt = dm_gnt;

  always_comb begin
    bus.sram_cs  = 1'b0;
    bus.sram_oe  = 1'b0;
    bus.sram_web = 4'hF;
    bus.sram_a   = '0;
    bus.sram_di  = '0;
    if (im_gnt) begin
      bus.sram_cs = 1'b1;
      bus.sram_oe = 1'b1;
      bus.sram_a  = bus.im_addr;
    end else if (dm_gnt) begin
      bus.sram_cs  = 1'b1;
      bus.sram_oe  = dm_rd;
      bus.sram_web = bus.dm_web;
      bus.sram_a   = bus.dm_addr;
      bus.sram_di  = bus.dm_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) rd_owner <= RD_NONE;
    else      rd_owner <= rd_owner_nxt;

  always_comb begin
    rd_owner_nxt = RD_NONE;
    if (im_gnt)     rd_owner_nxt = RD_IM;
    else if (dm_rd) rd_owner_nxt = RD_DM;
  end

  assign bus.im_rvalid = (rd_owner == RD_IM);
  assign bus.dm_rvalid = (rd_owner == RD_DM);

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      im_hold <= '0;
      dm_hold <= '0;
    end else begin
      if (rd_owner == RD_IM) im_hold <= bus.sram_do;
      if (rd_owner == RD_DM) dm_hold <= bus.sram_do;
    end

  assign bus.im_rdata = bus.im_rvalid ? bus.sram_do : im_hold;
  assign bus.dm_rdata = bus.dm_rvalid ? bus.sram_do : dm_hold;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: combinational grant/pin vector table, SRAM macro model,
// and a read-return scoreboard filled at grant time and drained on rvalid.
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if bus();
  sram_arbiter #(.STARVE_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM macro: DO registered, valid the cycle after the address edge
  logic [31:0] mem     [16384];
  logic [31:0] ref_mem [16384];
  always @(posedge clk) begin
    if (bus.sram_cs) begin
      if (bus.sram_oe) bus.sram_do <= mem[bus.sram_a];
      for (int b = 0; b < 4; b++)
        if (!bus.sram_web[b]) mem[bus.sram_a][b*8 +: 8] <= bus.sram_di[b*8 +: 8];
    end
  end

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    mem[a]     = d;
    ref_mem[a] = d;
  endtask

  // Scoreboard
  typedef struct { logic dm; logic [31:0] data; int due; } rd_item_t;
  rd_item_t    q[$];
  int          cyc = 0;
  logic [31:0] hold_im = '0, hold_dm = '0;

  always @(negedge clk) begin
    rd_item_t it;
    logic exp_imv, exp_dmv;
    exp_imv = 1'b0;
    exp_dmv = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      it = q.pop_front();
      if (it.dm) begin exp_dmv = 1'b1; hold_dm = it.data; end
      else       begin exp_imv = 1'b1; hold_im = it.data; end
    end
    check("im_rvalid", 32'(bus.im_rvalid), 32'(exp_imv));
    check("dm_rvalid", 32'(bus.dm_rvalid), 32'(exp_dmv));
    check("im_rdata",  bus.im_rdata, hold_im);
    check("dm_rdata",  bus.dm_rdata, hold_dm);
    check("gnt_exclusive", 32'(bus.im_gnt & bus.dm_gnt), 32'd0);
    if (bus.im_gnt) q.push_back('{1'b0, ref_mem[bus.im_addr], cyc + 1});
    if (bus.dm_gnt) begin
      if (bus.dm_web == 4'hF) q.push_back('{1'b1, ref_mem[bus.dm_addr], cyc + 1});
      else
        for (int b = 0; b < 4; b++)
          if (!bus.dm_web[b]) ref_mem[bus.dm_addr][b*8 +: 8] = bus.dm_wdata[b*8 +: 8];
    end
    cyc++;
  end

  task automatic idle_inputs();
    bus.im_req   = 1'b0;
    bus.im_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_web   = 4'hF;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Combinational vectors, applied and withdrawn between edges (counter/pointer at reset value)
  typedef struct {
    string       name;
    logic        im_req, dm_req;
    logic [3:0]  web;
    logic [13:0] ia, da;
    logic [31:0] wd;
    logic        e_ig, e_dg, e_cs, e_oe;
    logic [3:0]  e_web;
    logic [13:0] e_a;
    logic [31:0] e_di;
  } vec_t;

  vec_t vt[6];

  function automatic logic conflict_im(input int i);
`ifdef SRAM_ARB_RR_EN
    return (i % 2) == 1;
`else
    return (i % 5) == 4;
`endif
  endfunction

  initial begin
    vt[0] = '{"idle",     0, 0, 4'hF, 14'h000, 14'h000, 32'h0,        0, 0, 0, 0, 4'hF, 14'h000, 32'h0};
    vt[1] = '{"im_only",  1, 0, 4'hF, 14'h123, 14'h000, 32'h0,        1, 0, 1, 1, 4'hF, 14'h123, 32'h0};
    vt[2] = '{"dm_read",  0, 1, 4'hF, 14'h000, 14'h055, 32'h11112222, 0, 1, 1, 1, 4'hF, 14'h055, 32'h11112222};
    vt[3] = '{"dm_write", 0, 1, 4'h0, 14'h000, 14'h3FFF, 32'hFFFFFFFF, 0, 1, 1, 0, 4'h0, 14'h3FFF, 32'hFFFFFFFF};
    vt[4] = '{"conf_rd",  1, 1, 4'hF, 14'h007, 14'h009, 32'h0,        0, 1, 1, 1, 4'hF, 14'h009, 32'h0};
    vt[5] = '{"conf_wr",  1, 1, 4'hE, 14'h007, 14'h002, 32'h5,        0, 1, 1, 0, 4'hE, 14'h002, 32'h5};

    idle_inputs();
    bus.sram_do = '0;
    rst = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    #2;
    check("rst_im_gnt",   32'(bus.im_gnt), 0);
    check("rst_dm_gnt",   32'(bus.dm_gnt), 0);
    check("rst_sram_cs",  32'(bus.sram_cs), 0);
    check("rst_sram_oe",  32'(bus.sram_oe), 0);
    check("rst_sram_web", 32'(bus.sram_web), 32'hF);
    check("rst_sram_a",   32'(bus.sram_a), 0);
    check("rst_im_rdata", bus.im_rdata, 0);
    check("rst_dm_rdata", bus.dm_rdata, 0);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      bus.im_req = vt[i].im_req;  bus.dm_req  = vt[i].dm_req;
      bus.dm_web = vt[i].web;     bus.im_addr = vt[i].ia;
      bus.dm_addr = vt[i].da;     bus.dm_wdata = vt[i].wd;
      #1;
      check({vt[i].name, "_im_gnt"},   32'(bus.im_gnt),   32'(vt[i].e_ig));
      check({vt[i].name, "_dm_gnt"},   32'(bus.dm_gnt),   32'(vt[i].e_dg));
      check({vt[i].name, "_sram_cs"},  32'(bus.sram_cs),  32'(vt[i].e_cs));
      check({vt[i].name, "_sram_oe"},  32'(bus.sram_oe),  32'(vt[i].e_oe));
      check({vt[i].name, "_sram_web"}, 32'(bus.sram_web), 32'(vt[i].e_web));
      check({vt[i].name, "_sram_a"},   32'(bus.sram_a),   32'(vt[i].e_a));
      check({vt[i].name, "_sram_di"},  bus.sram_di,       vt[i].e_di);
      #1;
      idle_inputs();
    end

    // IM-only read, then hold
    preload(14'h010, 32'hDEADBEEF);
    next_cycle();
    bus.im_req = 1'b1; bus.im_addr = 14'h010;
    #2 check("im_read_gnt", 32'(bus.im_gnt), 1);
    next_cycle();
    idle_inputs();
    #2 check("im_read_rvalid", 32'(bus.im_rvalid), 1);
    check("im_read_data", bus.im_rdata, 32'hDEADBEEF);
    repeat (2) next_cycle();
    check("im_read_held", bus.im_rdata, 32'hDEADBEEF);

    // DM partial write then read back
    preload(14'h020, 32'hAAAAAAAA);
    next_cycle();
    bus.dm_req = 1'b1; bus.dm_web = 4'b1100; bus.dm_addr = 14'h020; bus.dm_wdata = 32'h12345678;
    next_cycle();
    bus.dm_web = 4'hF; bus.dm_wdata = '0;
    #2 check("dm_wr_no_rvalid", 32'(bus.dm_rvalid), 0);
    next_cycle();
    idle_inputs();
    #2 check("dm_rd_data", bus.dm_rdata, 32'hAAAA5678);
    next_cycle();

    // Sustained conflict
    preload(14'h050, 32'h0BADF00D);
    preload(14'h060, 32'h600D600D);
    next_cycle();
    bus.im_req = 1'b1; bus.im_addr = 14'h050;
    bus.dm_req = 1'b1; bus.dm_addr = 14'h060;
    for (int i = 0; i < 12; i++) begin
      #2;
      check($sformatf("conflict_im_gnt_%0d", i), 32'(bus.im_gnt), 32'(conflict_im(i)));
      check($sformatf("conflict_dm_gnt_%0d", i), 32'(bus.dm_gnt), 32'(!conflict_im(i)));
      next_cycle();
    end
    idle_inputs();
    repeat (2) next_cycle();

    // Reset with an IM read in flight
    preload(14'h030, 32'hCAFEF00D);
    bus.im_req = 1'b1; bus.im_addr = 14'h030;
    #2 check("rstmid_gnt", 32'(bus.im_gnt), 1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    q.delete();
    hold_im = '0;
    hold_dm = '0;
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("rstmid_no_rvalid", 32'(bus.im_rvalid), 0);
      check("rstmid_rdata", bus.im_rdata, 0);
      next_cycle();
    end

    // Back-to-back IM then DM reads
    preload(14'h040, 32'h01234567);
    preload(14'h041, 32'h89ABCDEF);
    bus.im_req = 1'b1; bus.im_addr = 14'h040;
    next_cycle();
    idle_inputs();
    bus.dm_req = 1'b1; bus.dm_addr = 14'h041;
    #2;
    check("b2b_dm_gnt",    32'(bus.dm_gnt), 1);
    check("b2b_im_rvalid", 32'(bus.im_rvalid), 1);
    check("b2b_im_rdata",  bus.im_rdata, 32'h01234567);
    next_cycle();
    idle_inputs();
    #2;
    check("b2b_dm_rvalid", 32'(bus.dm_rvalid), 1);
    check("b2b_dm_rdata",  bus.dm_rdata, 32'h89ABCDEF);
    repeat (2) next_cycle();
    check("scoreboard_drained", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-requester arbiter sharing one single-port `SRAM_wrapper` between the instruction-fetch port (read-only) and the data-memory port (read/write) of the 5-stage RISC-V core. It grants at most one access per cycle, drives the SRAM pins, and routes the one-cycle-late read data back to the owner. Each requester stalls on `req & ~gnt`. It sits between IF/MEM and a unified SRAM, replacing the separate IM/DM macros.

## Interface
- `STARVE_LIMIT`, default 4: consecutive denied IM cycles before IM overrides DM priority; legal range 1..15.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `im_req  in  1`: fetch request.
- `im_addr  in  14`: word address, `pc[15:2]`.
- `im_gnt  out  1`: fetch accepted this cycle.
- `im_rvalid  out  1`: fetch data valid.
- `im_rdata  out  32`: fetch data.
- `dm_req  in  1`: data request.
- `dm_web  in  4`: active-low byte write enables; `4'b1111` means read.
- `dm_addr  in  14`: word address.
- `dm_wdata  in  32`: write data.
- `dm_gnt  out  1`: data access accepted this cycle.
- `dm_rvalid  out  1`: load data valid.
- `dm_rdata  out  32`: load data.
- `sram_cs`, `sram_oe`  out  1 each: to SRAM `CS`/`OE`.
- `sram_web  out  4`: to SRAM `WEB`.
- `sram_a  out  14`: to SRAM `A`.
- `sram_di  out  32`: to SRAM `DI`.
- `sram_do  in  32`: from SRAM `DO`. Valid the cycle after the address edge.

## Operation
- Grant is combinational from `im_req`, `dm_req`, the starvation counter and the RR pointer. `im_gnt & dm_gnt` is never 1.
- Fixed priority (default): DM wins a conflict, except when `starve_cnt == STARVE_LIMIT`, in which case IM wins.
- `starve_cnt` is 4 bits. It increments on `im_req & ~im_gnt` and saturates at `STARVE_LIMIT`. It clears on `im_gnt` or `~im_req`.
- SRAM pins for a granted access:
  - `sram_cs = 1`, `sram_a` = owner address.
  - IM: `sram_web = 4'hF`, `sram_oe = 1`.
  - DM: `sram_web = dm_web`, `sram_di = dm_wdata`, `sram_oe = (dm_web == 4'hF)`.
- No grant: `cs = 0`, `oe = 0`, `web = 4'hF`, `a = 0`, `di = 0`.
- Return FSM, state `rd_owner` ∈ {NONE, IM, DM}, registered at each edge:
  - IM if `im_gnt`.
  - DM if `dm_gnt` and the access is a read.
  - Otherwise NONE (this includes DM writes).
- `im_rvalid = (rd_owner == IM)`; `dm_rvalid = (rd_owner == DM)`.
- Each rdata output is `sram_do` while its rvalid is high. Otherwise it holds the value captured at the last rvalid cycle (per-port 32-bit hold register).

## Timing
- Read latency: grant in cycle N, rvalid and data in cycle N+1.
- Back-to-back grants every cycle are allowed. rvalid for N and a grant for N+1 may coincide.
- Write completes at the grant edge and produces no rvalid.
- Requesters hold req, address and data stable until they see gnt. Dropping req before grant is legal and issues no access.
- Reset (asynchronous, `rst = 0`):
  - `rd_owner = NONE`, `starve_cnt = 0`, hold registers = 0, RR pointer = DM-first.
  - Outputs: gnt and rvalid 0, rdata 0, SRAM pins at their idle values.
- Reset asserted with a read in flight discards it; no rvalid follows reset release.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin on conflict.
  - A 1-bit pointer selects the winner and flips to the other port after each conflict grant.
  - Non-conflict grants do not move the pointer.
  - `starve_cnt` and `STARVE_LIMIT` are compiled out.
- `SRAM_ARB_RR_EN` undefined: DM fixed priority with the starvation override described above.

## Test plan
- Reset release with no requests:
  - all gnt/rvalid 0, rdata 0, `sram_web = 4'hF`, `sram_cs = 0`.
- IM-only read:
  - Stimulus: preload word 0x10 = 0xDEADBEEF; `im_req = 1`, `im_addr = 0x10` for one cycle.
  - Response: `im_gnt = 1` that cycle; next cycle `im_rvalid = 1`, `im_rdata = 0xDEADBEEF`; value held after.
- DM write then read:
  - Stimulus: `dm_web = 4'b1100`, `dm_wdata = 0x12345678`, addr 0x20 over old 0xAAAAAAAA; then read addr 0x20.
  - Response: no rvalid after the write; read returns 0xAAAA5678.
- Conflict, default build with `STARVE_LIMIT = 4`:
  - Stimulus: `im_req` and `dm_req` both held high for 12 cycles.
  - Response: DM granted 4 cycles, IM on the 5th, then the pattern repeats.
  - With `SRAM_ARB_RR_EN`: grants alternate DM, IM, DM, ...
- Reset mid-read:
  - Stimulus: IM granted, `rst = 0` before the next edge.
  - Response: no `im_rvalid` ever appears; `im_rdata = 0`.
- Back-to-back mixed traffic:
  - Stimulus: IM read at cycle 1, DM read at cycle 2.
  - Response: `im_rvalid` at cycle 2 and `dm_rvalid` at cycle 3, each with the correct word.
